mem_bus_arb: RTL and testbench

Two-requester arbiter that shares the core's single memory bus between instruction fetch and load/store. It sits between the fetch unit (fch_req/fch_rsp) and LSU (ldst_req/ldst_rsp) on one side and the bus master port on the other. It grants requests round-robin, tracks outstanding transactions in order, and routes responses back to their source. On a pipeline flush it silently drops responses to fetches already in flight.

---
 rtl/mem_bus_arb.sv | 202 ++++++++++++++++++++
 tb/tb_mem_bus_arb.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arb.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and load/store.
// An in-order tracker routes bus responses back to their source and silently drops flushed fetches.
module mem_bus_arb #(
  parameter int OST_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        fch_req_vld,
  output logic        fch_req_rdy,
  input  logic [31:0] fch_req_pc,
  output logic        fch_rsp_vld,
  input  logic        fch_rsp_rdy,
  output logic [31:0] fch_rsp_ir,
  input  logic        fl_vld,

  input  logic        ldst_req_vld,
  output logic        ldst_req_rdy,
  input  logic [31:0] ldst_req_addr,
  input  logic        ldst_req_st,
  input  logic [31:0] ldst_req_data,
  input  logic [3:0]  ldst_req_strobe,
  output logic        ldst_rsp_vld,
  input  logic        ldst_rsp_rdy,
  output logic [31:0] ldst_rsp_data,
  output logic        ldst_rsp_ok,

  output logic        bus_req_vld,
  input  logic        bus_req_rdy,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_st,
  output logic [31:0] bus_req_data,
  output logic [3:0]  bus_req_strobe,
  input  logic        bus_rsp_vld,
  output logic        bus_rsp_rdy,
  input  logic [31:0] bus_rsp_data,
  input  logic        bus_rsp_ok
);

  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = $clog2(OST_DEPTH) + 1;
  localparam logic SRC_FCH  = 1'b0;
  localparam logic SRC_LDST = 1'b1;

  // Tracker storage: one source bit and one drop bit per outstanding transaction.
  logic [OST_DEPTH-1:0] r_src;
  logic [OST_DEPTH-1:0] r_drop;
  logic [OST_DEPTH-1:0] w_src_next;
  logic [OST_DEPTH-1:0] w_drop_next;
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic r_lock;
  logic r_lock_src;
  logic r_last;
  logic r_drop_lock;

  logic w_full;
  logic w_empty;
  logic w_fch_elig;
  logic w_gnt_src;
  logic w_gnt_vld;
  logic w_push;
  logic w_pop;
  logic w_push_drop;
  logic w_head_src;
  logic w_head_drop;

  assign w_full      = (r_count == CW'(OST_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_fch_elig  = fch_req_vld && !fl_vld;
  assign w_push      = bus_req_vld && bus_req_rdy;
  assign w_pop       = bus_rsp_vld && bus_rsp_rdy;
  assign w_head_src  = r_src[r_rptr];
  assign w_head_drop = r_drop[r_rptr];
  // A fetch pushed during a flush, or one that was locked when a flush hit, is born dropped.
  assign w_push_drop = (w_gnt_src == SRC_FCH) && (fl_vld || r_drop_lock);

  // Grant selection depends only on registered state and source valids, never on bus_req_rdy.
  always_comb begin
    w_gnt_src = SRC_FCH;
    w_gnt_vld = 1'b0;
    if (!w_full) begin
      if (r_lock) begin
        w_gnt_src = r_lock_src;
        w_gnt_vld = (r_lock_src == SRC_LDST) ? ldst_req_vld : fch_req_vld;
      end else if (w_fch_elig && ldst_req_vld) begin
        w_gnt_src = ~r_last;
        w_gnt_vld = 1'b1;
      end else if (w_fch_elig) begin
        w_gnt_src = SRC_FCH;
        w_gnt_vld = 1'b1;
      end else if (ldst_req_vld) begin
        w_gnt_src = SRC_LDST;
        w_gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    bus_req_vld    = w_gnt_vld;
    bus_req_addr   = 32'h0;
    bus_req_st     = 1'b0;
    bus_req_data   = 32'h0;
    bus_req_strobe = 4'h0;
    fch_req_rdy    = 1'b0;
    ldst_req_rdy   = 1'b0;
    if (w_gnt_vld) begin
      if (w_gnt_src == SRC_LDST) begin
        bus_req_addr   = ldst_req_addr;
        bus_req_st     = ldst_req_st;
        bus_req_data   = ldst_req_data;
        bus_req_strobe = ldst_req_strobe;
        ldst_req_rdy   = bus_req_rdy;
      end else begin
        bus_req_addr   = fch_req_pc;
        bus_req_strobe = 4'hF;
        fch_req_rdy    = bus_req_rdy;
      end
    end
  end

  always_comb begin
    fch_rsp_vld   = 1'b0;
    fch_rsp_ir    = 32'h0;
    ldst_rsp_vld  = 1'b0;
    ldst_rsp_data = 32'h0;
    ldst_rsp_ok   = 1'b0;
    bus_rsp_rdy   = 1'b0;
    if (!w_empty) begin
      if (w_head_drop) begin
        bus_rsp_rdy = 1'b1;
      end else if (w_head_src == SRC_FCH) begin
        fch_rsp_vld = bus_rsp_vld;
        fch_rsp_ir  = bus_rsp_data;
        bus_rsp_rdy = fch_rsp_rdy;
      end else begin
        ldst_rsp_vld  = bus_rsp_vld;
        ldst_rsp_data = bus_rsp_data;
        ldst_rsp_ok   = bus_rsp_ok;
        bus_rsp_rdy   = ldst_rsp_rdy;
      end
    end
  end

  // Per-entry update: a push overwrites the slot, otherwise a flush marks fetch slots dropped.
  for (genvar gi = 0; gi < OST_DEPTH; gi++) begin : g_entry
    logic w_hit;
    assign w_hit = w_push && (r_wptr == PW'(gi));
    assign w_src_next[gi]  = w_hit ? w_gnt_src : r_src[gi];
    assign w_drop_next[gi] = w_hit ? w_push_drop
                           : (r_drop[gi] || (fl_vld && (r_src[gi] == SRC_FCH)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_drop  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_src  <= w_src_next;
      r_drop <= w_drop_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock      <= 1'b0;
      r_lock_src  <= SRC_FCH;
      r_last      <= SRC_LDST;
      r_drop_lock <= 1'b0;
    end else begin
      if (w_push) begin
        r_lock <= 1'b0;
        r_last <= w_gnt_src;
      end else if (bus_req_vld && !bus_req_rdy) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_gnt_src;
      end
      if (w_push && (w_gnt_src == SRC_FCH)) begin
        r_drop_lock <= 1'b0;
      end else if (fl_vld && r_lock && (r_lock_src == SRC_FCH)) begin
        r_drop_lock <= 1'b1;
      end
    end
  end

  a_rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus_rsp_vld && w_empty))
    else $error("bus response with no outstanding transaction");

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: a bus responder model plus scoreboards of expected bus requests
// and expected fetch/LSU responses, checked whenever the DUT completes a transfer.
module tb_mem_bus_arb;

  logic        clk;
  logic        rst_n;
  logic        fch_req_vld, fch_req_rdy;
  logic [31:0] fch_req_pc;
  logic        fch_rsp_vld, fch_rsp_rdy;
  logic [31:0] fch_rsp_ir;
  logic        fl_vld;
  logic        ldst_req_vld, ldst_req_rdy;
  logic [31:0] ldst_req_addr;
  logic        ldst_req_st;
  logic [31:0] ldst_req_data;
  logic [3:0]  ldst_req_strobe;
  logic        ldst_rsp_vld, ldst_rsp_rdy;
  logic [31:0] ldst_rsp_data;
  logic        ldst_rsp_ok;
  logic        bus_req_vld, bus_req_rdy;
  logic [31:0] bus_req_addr;
  logic        bus_req_st;
  logic [31:0] bus_req_data;
  logic [3:0]  bus_req_strobe;
  logic        bus_rsp_vld, bus_rsp_rdy;
  logic [31:0] bus_rsp_data;
  logic        bus_rsp_ok;

  int errors = 0;
  int checks = 0;

  logic [68:0] exp_bus[$];
  logic [31:0] exp_fch[$];
  logic [32:0] exp_ldst[$];
  logic [31:0] pend_d[$];
  logic        pend_ok[$];

  logic        rsp_en = 1'b0;
  logic        req_seen = 1'b0;
  logic        rsp_seen = 1'b0;
  logic [31:0] req_addr_cap = 32'h0;
  logic [68:0] mon_e;
  logic [31:0] mon_f;
  logic [32:0] mon_l;

  mem_bus_arb #(.OST_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .fch_req_vld(fch_req_vld), .fch_req_rdy(fch_req_rdy), .fch_req_pc(fch_req_pc),
    .fch_rsp_vld(fch_rsp_vld), .fch_rsp_rdy(fch_rsp_rdy), .fch_rsp_ir(fch_rsp_ir),
    .fl_vld(fl_vld),
    .ldst_req_vld(ldst_req_vld), .ldst_req_rdy(ldst_req_rdy), .ldst_req_addr(ldst_req_addr),
    .ldst_req_st(ldst_req_st), .ldst_req_data(ldst_req_data), .ldst_req_strobe(ldst_req_strobe),
    .ldst_rsp_vld(ldst_rsp_vld), .ldst_rsp_rdy(ldst_rsp_rdy), .ldst_rsp_data(ldst_rsp_data),
    .ldst_rsp_ok(ldst_rsp_ok),
    .bus_req_vld(bus_req_vld), .bus_req_rdy(bus_req_rdy), .bus_req_addr(bus_req_addr),
    .bus_req_st(bus_req_st), .bus_req_data(bus_req_data), .bus_req_strobe(bus_req_strobe),
    .bus_rsp_vld(bus_rsp_vld), .bus_rsp_rdy(bus_rsp_rdy), .bus_rsp_data(bus_rsp_data),
    .bus_rsp_ok(bus_rsp_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h100)  return 32'h0000_0013;
    if (a == 32'h3000) return 32'h0000_0055;
    return ~a;
  endfunction

  function automatic logic mem_ok(input logic [31:0] a);
    return (a != 32'h4000);
  endfunction

  // Scoreboard monitor: away from the active edge, compare every completed transfer.
  always @(negedge clk) begin
    req_seen = 1'b0;
    rsp_seen = 1'b0;
    if (rst_n) begin
      if (bus_req_vld && bus_req_rdy) begin
        req_seen     = 1'b1;
        req_addr_cap = bus_req_addr;
        $display("[%0t] bus req addr=%h st=%0d data=%h strobe=%h",
                 $time, bus_req_addr, bus_req_st, bus_req_data, bus_req_strobe);
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_req: unexpected request addr=%h", bus_req_addr);
        end else begin
          mon_e = exp_bus.pop_front();
          if ({bus_req_addr, bus_req_st, bus_req_data, bus_req_strobe} !== mon_e) begin
            errors++;
            $display("FAIL bus_req: got %h want %h",
                     {bus_req_addr, bus_req_st, bus_req_data, bus_req_strobe}, mon_e);
          end
        end
      end
      rsp_seen = bus_rsp_vld && bus_rsp_rdy;
      if (fch_rsp_vld && fch_rsp_rdy) begin
        $display("[%0t] fch rsp ir=%h", $time, fch_rsp_ir);
        checks++;
        if (exp_fch.size() == 0) begin
          errors++;
          $display("FAIL fch_rsp: unexpected ir=%h", fch_rsp_ir);
        end else begin
          mon_f = exp_fch.pop_front();
          if (fch_rsp_ir !== mon_f) begin
            errors++;
            $display("FAIL fch_rsp: got %h want %h", fch_rsp_ir, mon_f);
          end
        end
      end
      if (ldst_rsp_vld && ldst_rsp_rdy) begin
        $display("[%0t] ldst rsp data=%h ok=%0d", $time, ldst_rsp_data, ldst_rsp_ok);
        checks++;
        if (exp_ldst.size() == 0) begin
          errors++;
          $display("FAIL ldst_rsp: unexpected data=%h", ldst_rsp_data);
        end else begin
          mon_l = exp_ldst.pop_front();
          if ({ldst_rsp_data, ldst_rsp_ok} !== mon_l) begin
            errors++;
            $display("FAIL ldst_rsp: got %h want %h", {ldst_rsp_data, ldst_rsp_ok}, mon_l);
          end
        end
      end
    end
  end

  // Bus slave: answers every accepted request in order while rsp_en is set.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      pend_d.delete();
      pend_ok.delete();
    end else begin
      if (rsp_seen && pend_d.size() > 0) begin
        void'(pend_d.pop_front());
        void'(pend_ok.pop_front());
      end
      if (req_seen) begin
        pend_d.push_back(mem_rd(req_addr_cap));
        pend_ok.push_back(mem_ok(req_addr_cap));
      end
    end
    if (rsp_en && rst_n && pend_d.size() > 0) begin
      bus_rsp_vld  = 1'b1;
      bus_rsp_data = pend_d[0];
      bus_rsp_ok   = pend_ok[0];
    end else begin
      bus_rsp_vld  = 1'b0;
      bus_rsp_data = 32'h0;
      bus_rsp_ok   = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    rsp_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pend_d.size() == 0 && exp_fch.size() == 0 && exp_ldst.size() == 0 && !bus_rsp_vld) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic push_fetch(input logic [31:0] pc, input bit delivered);
    exp_bus.push_back({pc, 1'b0, 32'h0, 4'hF});
    if (delivered) exp_fch.push_back(mem_rd(pc));
  endtask

  task automatic push_ldst(input logic [31:0] a, input logic st, input logic [31:0] d,
                           input logic [3:0] s);
    exp_bus.push_back({a, st, d, s});
    exp_ldst.push_back({mem_rd(a), mem_ok(a)});
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_req_vld, fch_req_rdy, ldst_req_rdy, fch_rsp_vld, ldst_rsp_vld, bus_rsp_rdy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000",
               {bus_req_vld, fch_req_rdy, ldst_req_rdy, fch_rsp_vld, ldst_rsp_vld, bus_rsp_rdy});
    end
    checks++;
    if ({bus_req_addr, bus_req_st, bus_req_data, bus_req_strobe, fch_rsp_ir, ldst_rsp_data, ldst_rsp_ok} !== '0) begin
      errors++;
      $display("FAIL reset_payload: addr=%h strobe=%h ir=%h want all 0", bus_req_addr, bus_req_strobe, fch_rsp_ir);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus_req_vld, bus_rsp_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle: got %b want 00", {bus_req_vld, bus_rsp_rdy});
    end
  endtask

  task automatic test_contention();
    bit ok;
    fch_req_vld = 1'b1; fch_req_pc = 32'h200;
    ldst_req_vld = 1'b1; ldst_req_addr = 32'h2000; ldst_req_st = 1'b1;
    ldst_req_data = 32'hDEAD_BEEF; ldst_req_strobe = 4'h3;
    bus_req_rdy = 1'b1; rsp_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if ({fch_req_rdy, ldst_req_rdy} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_grant[%0d]: rdy fch/ldst=%b want %b", k,
                 {fch_req_rdy, ldst_req_rdy}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k % 2 == 0) push_fetch(32'h200, 1'b1);
      else push_ldst(32'h2000, 1'b1, 32'hDEAD_BEEF, 4'h3);
      tick();
    end
    fch_req_vld = 1'b0; ldst_req_vld = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL contention_drain: timeout got pending want none"); end
  endtask

  task automatic test_backpressure_lock();
    bit ok;
    ldst_req_vld = 1'b1; ldst_req_addr = 32'h4000; ldst_req_st = 1'b0;
    ldst_req_data = 32'h1111_2222; ldst_req_strobe = 4'hF;
    bus_req_rdy = 1'b0;
    #1;
    checks++;
    if ({bus_req_vld, ldst_req_rdy, bus_req_addr} !== {2'b10, 32'h4000}) begin
      errors++;
      $display("FAIL bp_first: vld=%b rdy=%b addr=%h want 1 0 4000", bus_req_vld, ldst_req_rdy, bus_req_addr);
    end
    tick();
    fch_req_vld = 1'b1; fch_req_pc = 32'h300;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({bus_req_vld, fch_req_rdy, bus_req_addr, bus_req_st, bus_req_data} !==
          {2'b10, 32'h4000, 1'b0, 32'h1111_2222}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b fch_rdy=%b addr=%h data=%h want 1 0 4000 11112222",
                 k, bus_req_vld, fch_req_rdy, bus_req_addr, bus_req_data);
      end
      tick();
    end
    bus_req_rdy = 1'b1;
    push_ldst(32'h4000, 1'b0, 32'h1111_2222, 4'hF);
    #1;
    checks++;
    if ({ldst_req_rdy, fch_req_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: rdy ldst/fch=%b want 10", {ldst_req_rdy, fch_req_rdy});
    end
    tick();
    ldst_req_vld = 1'b0;
    push_fetch(32'h300, 1'b1);
    #1;
    checks++;
    if ({fch_req_rdy, bus_req_addr} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL bp_next_fetch: rdy=%b addr=%h want 1 300", fch_req_rdy, bus_req_addr);
    end
    tick();
    fch_req_vld = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain: timeout got pending want none"); end
  endtask

  task automatic test_single_fetch();
    bit ok;
    bit seen;
    rsp_en = 1'b0;
    fch_req_vld = 1'b1; fch_req_pc = 32'h100; bus_req_rdy = 1'b1;
    push_fetch(32'h100, 1'b1);
    #1;
    checks++;
    if ({bus_req_vld, fch_req_rdy, ldst_req_rdy} !== 3'b110) begin
      errors++;
      $display("FAIL single_req: vld/fch_rdy/ldst_rdy=%b want 110", {bus_req_vld, fch_req_rdy, ldst_req_rdy});
    end
    tick();
    fch_req_vld = 1'b0;
    tick();
    tick();
    rsp_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ldst_rsp_vld) begin
        checks++; errors++;
        $display("FAIL single_ldst_quiet: ldst_rsp_vld=1 want 0");
      end
      if (fch_rsp_vld) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || fch_rsp_ir !== 32'h0000_0013) begin
      errors++;
      $display("FAIL single_rsp: seen=%0d ir=%h want 1 00000013", seen, fch_rsp_ir);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain: timeout got pending want none"); end
  endtask

  task automatic test_full_tracker();
    bit ok;
    rsp_en = 1'b0; bus_req_rdy = 1'b1;
    fch_req_vld = 1'b1; fch_req_pc = 32'h400; push_fetch(32'h400, 1'b1);
    tick();
    fch_req_pc = 32'h404; push_fetch(32'h404, 1'b1);
    tick();
    fch_req_pc = 32'h408;
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++;
      if ({bus_req_vld, fch_req_rdy, ldst_req_rdy} !== 3'b000) begin
        errors++;
        $display("FAIL full_block[%0d]: vld/fch_rdy/ldst_rdy=%b want 000", k,
                 {bus_req_vld, fch_req_rdy, ldst_req_rdy});
      end
      tick();
    end
    rsp_en = 1'b1;
    #3;
    checks++;
    if ({bus_rsp_rdy, bus_req_vld} !== 2'b10) begin
      errors++;
      $display("FAIL full_no_bypass: rsp_rdy/req_vld=%b want 10", {bus_rsp_rdy, bus_req_vld});
    end
    tick();
    push_fetch(32'h408, 1'b1);
    #3;
    checks++;
    if ({bus_req_vld, fch_req_rdy, bus_req_addr} !== {2'b11, 32'h408}) begin
      errors++;
      $display("FAIL full_resume: vld=%b rdy=%b addr=%h want 1 1 408", bus_req_vld, fch_req_rdy, bus_req_addr);
    end
    tick();
    fch_req_vld = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_drain: timeout got pending want none"); end
  endtask

  task automatic test_flush_drop();
    bit ok;
    rsp_en = 1'b0; bus_req_rdy = 1'b1;
    fch_req_vld = 1'b1; fch_req_pc = 32'h500; push_fetch(32'h500, 1'b0);
    tick();
    fch_req_vld = 1'b0;
    ldst_req_vld = 1'b1; ldst_req_addr = 32'h3000; ldst_req_st = 1'b0;
    ldst_req_data = 32'h0; ldst_req_strobe = 4'hF;
    push_ldst(32'h3000, 1'b0, 32'h0, 4'hF);
    tick();
    ldst_req_vld = 1'b0; fl_vld = 1'b1;
    tick();
    fl_vld = 1'b0; rsp_en = 1'b1;
    #3;
    checks++;
    if ({bus_rsp_vld, bus_rsp_rdy, fch_rsp_vld} !== 3'b110) begin
      errors++;
      $display("FAIL flush_drop_fetch: bus_vld/bus_rdy/fch_vld=%b want 110", {bus_rsp_vld, bus_rsp_rdy, fch_rsp_vld});
    end
    tick();
    #3;
    checks++;
    if ({ldst_rsp_vld, ldst_rsp_data, ldst_rsp_ok} !== {1'b1, 32'h55, 1'b1}) begin
      errors++;
      $display("FAIL flush_load: vld=%b data=%h ok=%b want 1 00000055 1", ldst_rsp_vld, ldst_rsp_data, ldst_rsp_ok);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_drain1: timeout got pending want none"); end

    fch_req_vld = 1'b1; fch_req_pc = 32'h600; fl_vld = 1'b1;
    #1;
    checks++;
    if ({bus_req_vld, fch_req_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_inelig: vld/rdy=%b want 00", {bus_req_vld, fch_req_rdy});
    end
    tick();
    fl_vld = 1'b0; bus_req_rdy = 1'b0;
    tick();
    fl_vld = 1'b1;
    #1;
    checks++;
    if ({bus_req_vld, fch_req_rdy, bus_req_addr} !== {2'b10, 32'h600}) begin
      errors++;
      $display("FAIL flush_locked: vld=%b rdy=%b addr=%h want 1 0 600", bus_req_vld, fch_req_rdy, bus_req_addr);
    end
    tick();
    fl_vld = 1'b0; bus_req_rdy = 1'b1;
    push_fetch(32'h600, 1'b0);
    tick();
    fch_req_pc = 32'h604; push_fetch(32'h604, 1'b1);
    #3;
    checks++;
    if ({bus_rsp_vld, bus_rsp_rdy, fch_rsp_vld} !== 3'b110) begin
      errors++;
      $display("FAIL flush_drop_locked: bus_vld/bus_rdy/fch_vld=%b want 110", {bus_rsp_vld, bus_rsp_rdy, fch_rsp_vld});
    end
    tick();
    fch_req_vld = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_drain2: timeout got pending want none"); end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    rsp_en = 1'b0; bus_req_rdy = 1'b1;
    fch_req_vld = 1'b1; fch_req_pc = 32'h700; push_fetch(32'h700, 1'b0);
    tick();
    fch_req_pc = 32'h704; push_fetch(32'h704, 1'b0);
    tick();
    rst_n = 1'b0; fch_req_vld = 1'b0; ldst_req_vld = 1'b0;
    #1;
    checks++;
    if ({bus_req_vld, fch_req_rdy, ldst_req_rdy, fch_rsp_vld, ldst_rsp_vld, bus_rsp_rdy, bus_req_addr} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: ctl=%b addr=%h want 0",
               {bus_req_vld, fch_req_rdy, ldst_req_rdy, fch_rsp_vld, ldst_rsp_vld, bus_rsp_rdy}, bus_req_addr);
    end
    tick();
    tick();
    rst_n = 1'b1; rsp_en = 1'b1;
    fch_req_vld = 1'b1; fch_req_pc = 32'h800;
    ldst_req_vld = 1'b1; ldst_req_addr = 32'h2000; ldst_req_st = 1'b1;
    ldst_req_data = 32'hDEAD_BEEF; ldst_req_strobe = 4'h3;
    push_fetch(32'h800, 1'b1);
    #1;
    checks++;
    if ({fch_req_rdy, ldst_req_rdy, bus_req_addr} !== {2'b10, 32'h800}) begin
      errors++;
      $display("FAIL midreset_first_grant: rdy=%b addr=%h want 10 800", {fch_req_rdy, ldst_req_rdy}, bus_req_addr);
    end
    tick();
    fch_req_vld = 1'b0;
    push_ldst(32'h2000, 1'b1, 32'hDEAD_BEEF, 4'h3);
    #1;
    checks++;
    if (ldst_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_second_grant: ldst_rdy=%b want 1", ldst_req_rdy);
    end
    tick();
    ldst_req_vld = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_drain: timeout got pending want none"); end
  endtask

  task automatic test_final();
    checks++;
    if (exp_bus.size() != 0 || exp_fch.size() != 0 || exp_ldst.size() != 0) begin
      errors++;
      $display("FAIL leftovers: bus=%0d fch=%0d ldst=%0d want 0 0 0",
               exp_bus.size(), exp_fch.size(), exp_ldst.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fch_req_vld = 1'b0; fch_req_pc = 32'h0; fch_rsp_rdy = 1'b1; fl_vld = 1'b0;
    ldst_req_vld = 1'b0; ldst_req_addr = 32'h0; ldst_req_st = 1'b0;
    ldst_req_data = 32'h0; ldst_req_strobe = 4'h0; ldst_rsp_rdy = 1'b1;
    bus_req_rdy = 1'b0; bus_rsp_vld = 1'b0; bus_rsp_data = 32'h0; bus_rsp_ok = 1'b0;
    test_reset();
    test_contention();
    test_backpressure_lock();
    test_single_fetch();
    test_full_tracker();
    test_flush_drop();
    test_reset_mid_op();
    test_final();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
